// File: rtl/root_pkg.sv
// Shared digit encoding, default parameters and fixed-point widths for the
// radix-2 online square-root unit.
package root_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned P_DEFAULT = 1;

  typedef logic [1:0] sd_t;

  localparam sd_t DIG_ZERO = 2'b00;
  localparam sd_t DIG_POS  = 2'b01;
  localparam sd_t DIG_NEG  = 2'b10;

  // Residual holds 2 integer bits; the estimate path carries 2 extra guard bits.
  localparam int unsigned RES_INT  = 2;
  localparam int unsigned GUARD    = 2;
  localparam int unsigned EST_FRAC = 3;
  localparam int unsigned EST_W    = RES_INT + GUARD + EST_FRAC;

  localparam logic signed [EST_W-1:0] EST_HALF  = EST_W'(4);
  localparam logic signed [EST_W-1:0] EST_NHALF = -EST_HALF;

  function automatic int unsigned res_frac(input int unsigned n);
    return n + 3;
  endfunction

  function automatic int unsigned res_width(input int unsigned n);
    return n + 3 + RES_INT;
  endfunction

endpackage

// File: rtl/root_select.sv
// Digit selection: truncates the residual estimate to 3 fraction bits and
// compares it against +/-1/2.
module root_select
  import root_pkg::*;
#(
  parameter int unsigned F  = 11,
  parameter int unsigned WW = 15
) (
  input  logic signed [WW-1:0] i_est,
  output sd_t                  o_dig_c
);

  logic signed [EST_W-1:0] w_trunc;

  assign w_trunc = EST_W'(i_est >>> (F - EST_FRAC));

  always_comb begin
    o_dig_c = DIG_ZERO;
    if (w_trunc >= EST_HALF) begin
      o_dig_c = DIG_POS;
    end else if (w_trunc < EST_NHALF) begin
      o_dig_c = DIG_NEG;
    end
  end

endmodule

// File: rtl/root_algorithm.sv
// Radix-2 online square root, MSD first, online delay 1. Residual recurrence in
// exact fixed point with on-the-fly conversion of the root into Q/QM.
module root_algorithm
  import root_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned P = P_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_Reset,
  input  logic [1:0] i_x,
  output logic [1:0] o_y
);

  localparam int unsigned F       = res_frac(N);
  localparam int unsigned W       = res_width(N);
  localparam int unsigned WW      = W + GUARD;
  localparam int unsigned CNT_MAX = F + P;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic signed [WW-1:0] X_HALF = WW'(1) <<< (F - 1);

  logic signed [W-1:0]  r_w;
  logic signed [W-1:0]  r_q;
  logic signed [W-1:0]  r_qm;
  logic [CW-1:0]        r_cnt;
  sd_t                  r_y;

  logic signed [WW-1:0] w_xterm;
  logic signed [WW-1:0] w_est;
  logic signed [WW-1:0] w_2q;
  logic signed [WW-1:0] w_bitx;
  logic signed [WW-1:0] w_next;
  logic signed [W-1:0]  w_bit;
  logic signed [W-1:0]  w_q_nxt;
  logic signed [W-1:0]  w_qm_nxt;
  logic [CW-1:0]        w_k;
  logic                 w_slot;
  sd_t                  w_sel_c;
  sd_t                  w_dig;

  // Estimate 2w + x/2; code 11 on the input falls through to zero.
  always_comb begin
    w_xterm = '0;
    case (i_x)
      DIG_POS: w_xterm = X_HALF;
      DIG_NEG: w_xterm = -X_HALF;
      default: w_xterm = '0;
    endcase
    w_est = (WW'(r_w) <<< 1) + w_xterm;
  end

  root_select #(
    .F  (F),
    .WW (WW)
  ) u_select (
    .i_est   (w_est),
    .o_dig_c (w_sel_c)
  );

  // Digit weight 2^-k, residual update and on-the-fly Q/QM append.
  always_comb begin
    w_slot   = (r_cnt < CW'(P));
    w_k      = r_cnt - CW'(P) + CW'(1);
    w_bit    = '0;
    if (!w_slot && (w_k <= CW'(F))) begin
      w_bit = W'(1) <<< (CW'(F) - w_k);
    end
    w_dig    = w_slot ? DIG_ZERO : w_sel_c;
    w_2q     = WW'(r_q) <<< 1;
    w_bitx   = WW'(w_bit);
    w_next   = w_est;
    w_q_nxt  = r_q;
    w_qm_nxt = r_qm | w_bit;
    case (w_dig)
      DIG_POS: begin
        w_next   = w_est - (w_2q + w_bitx);
        w_q_nxt  = r_q | w_bit;
        w_qm_nxt = r_q;
      end
      DIG_NEG: begin
        w_next   = w_est + (w_2q - w_bitx);
        w_q_nxt  = r_qm | w_bit;
        w_qm_nxt = r_qm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_w   <= '0;
      r_q   <= '0;
      r_qm  <= '0;
      r_cnt <= '0;
      r_y   <= DIG_ZERO;
    end else begin
      r_w  <= W'(w_next);
      r_q  <= w_q_nxt;
      r_qm <= w_qm_nxt;
      r_y  <= w_dig;
      if (r_cnt != CW'(CNT_MAX)) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: tb/tb_root_algorithm.sv
// Directed bench for root_algorithm: hand-computed digit streams and root
// values for the operands of interest, including async reset mid-stream.
`timescale 1ns/1ps
module tb_root_algorithm;
  import root_pkg::*;

  logic       i_clk;
  logic       i_Reset;
  logic [1:0] i_x;
  logic [1:0] o_y;

  int n_vec;
  int n_err;

  logic [1:0] x_vec [1:9];
  logic [1:0] y_got [1:9];

  // x = 1,0,-1,-1,0,0,0,1 + flush; sqrt = 0.1001b, digits 1,1,-1,-1,0,0,0,0
  localparam logic [17:0] CASE1 = {DIG_POS, DIG_ZERO, DIG_NEG, DIG_NEG, DIG_ZERO,
                                   DIG_ZERO, DIG_ZERO, DIG_POS, DIG_ZERO};
  localparam logic [17:0] CASE1_11 = {DIG_POS, 2'b11, DIG_NEG, DIG_NEG, 2'b11,
                                      2'b11, 2'b11, DIG_POS, 2'b11};
  localparam logic [17:0] QUARTER  = {DIG_ZERO, DIG_POS, 14'b0};
  localparam logic [17:0] QUARTER_R = {DIG_POS, DIG_NEG, 14'b0};
  localparam logic [17:0] ALL_ONES = {DIG_POS, DIG_POS, DIG_POS, DIG_POS, DIG_POS,
                                      DIG_POS, DIG_POS, DIG_POS, DIG_ZERO};

  root_algorithm #(.N(8), .P(1)) dut (
    .i_clk   (i_clk),
    .i_Reset (i_Reset),
    .i_x     (i_x),
    .o_y     (o_y)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [1:0] exp_case1(input int k);
    case (k)
      1, 2:    return DIG_POS;
      3, 4:    return DIG_NEG;
      default: return DIG_ZERO;
    endcase
  endfunction

  function automatic int dig_val(input logic [1:0] d);
    case (d)
      2'b01:   return 1;
      2'b10:   return -1;
      default: return 0;
    endcase
  endfunction

  // Root value in units of 2^-8 from y1..y8 (captured after edges 2..9).
  function automatic int y_value();
    int v;
    v = 0;
    for (int k = 1; k <= 8; k++) v += dig_val(y_got[k+1]) * (1 << (8 - k));
    return v;
  endfunction

  function automatic int count_11();
    int c;
    c = 0;
    for (int e = 1; e <= 9; e++) if (y_got[e] == 2'b11) c++;
    return c;
  endfunction

  task automatic load_x(input logic [17:0] p);
    for (int e = 1; e <= 9; e++) x_vec[e] = p[2*(9-e)+1 -: 2];
  endtask

  task automatic start_operand();
    i_x     = DIG_ZERO;
    i_Reset = 1'b0;
    @(negedge i_clk);
    i_Reset = 1'b1;
  endtask

  task automatic run_edges(input int n);
    for (int e = 1; e <= n; e++) begin
      i_x = x_vec[e];
      @(posedge i_clk);
      #1;
      y_got[e] = o_y;
    end
    i_x = DIG_ZERO;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    i_x     = DIG_POS;
    #1;
    n_vec++;
    if (o_y !== DIG_ZERO) begin
      n_err++;
      $display("FAIL reset_now: o_y=%b expected %b", o_y, DIG_ZERO);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge i_clk);
      #1;
      n_vec++;
      if (o_y !== DIG_ZERO) begin
        n_err++;
        $display("FAIL reset_held[%0d]: o_y=%b expected %b", c, o_y, DIG_ZERO);
      end
    end
  endtask

  task automatic test_case1();
    start_operand();
    load_x(CASE1);
    run_edges(9);
    n_vec++;
    if (y_got[1] !== DIG_ZERO) begin
      n_err++;
      $display("FAIL case1_slot: o_y=%b expected %b", y_got[1], DIG_ZERO);
    end
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (y_got[k+1] !== exp_case1(k)) begin
        n_err++;
        $display("FAIL case1_digit y%0d: o_y=%b expected %b", k, y_got[k+1], exp_case1(k));
      end
    end
    n_vec++;
    if (y_value() !== 144) begin
      n_err++;
      $display("FAIL case1_value: got %0d/256 expected 144/256", y_value());
    end
    n_vec++;
    if (count_11() !== 0) begin
      n_err++;
      $display("FAIL case1_code11: %0d illegal digits expected 0", count_11());
    end
  endtask

  task automatic test_quarter();
    start_operand();
    load_x(QUARTER);
    run_edges(9);
    n_vec++;
    if (y_got[1] !== DIG_ZERO) begin
      n_err++;
      $display("FAIL quarter_slot: o_y=%b expected %b", y_got[1], DIG_ZERO);
    end
    n_vec++;
    if (y_value() !== 128) begin
      n_err++;
      $display("FAIL quarter_value: got %0d/256 expected 128/256", y_value());
    end
  endtask

  task automatic test_redundant_quarter();
    start_operand();
    load_x(QUARTER_R);
    run_edges(9);
    n_vec++;
    if (y_value() !== 128) begin
      n_err++;
      $display("FAIL redundant_value: got %0d/256 expected 128/256", y_value());
    end
  endtask

  task automatic test_all_ones();
    int v;
    start_operand();
    load_x(ALL_ONES);
    run_edges(9);
    v = y_value();
    // sqrt(1-2^-8)*256 = 255.5; within one ulp means 255 or 256
    n_vec++;
    if (!(v >= 255 && v <= 256)) begin
      n_err++;
      $display("FAIL all_ones_value: got %0d/256 expected 255..256/256", v);
    end
    n_vec++;
    if (count_11() !== 0) begin
      n_err++;
      $display("FAIL all_ones_code11: %0d illegal digits expected 0", count_11());
    end
  endtask

  task automatic test_zero();
    start_operand();
    load_x(18'b0);
    run_edges(9);
    for (int e = 1; e <= 9; e++) begin
      n_vec++;
      if (y_got[e] !== DIG_ZERO) begin
        n_err++;
        $display("FAIL zero_digit edge%0d: o_y=%b expected %b", e, y_got[e], DIG_ZERO);
      end
    end
  endtask

  task automatic test_code11_input();
    start_operand();
    load_x(CASE1_11);
    run_edges(9);
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (y_got[k+1] !== exp_case1(k)) begin
        n_err++;
        $display("FAIL code11_digit y%0d: o_y=%b expected %b", k, y_got[k+1], exp_case1(k));
      end
    end
  endtask

  task automatic test_midstream_reset();
    start_operand();
    load_x(CASE1);
    run_edges(4);
    n_vec++;
    if (y_got[4] !== DIG_NEG) begin
      n_err++;
      $display("FAIL mid_pre_y3: o_y=%b expected %b", y_got[4], DIG_NEG);
    end
    #2;
    i_Reset = 1'b0;
    #1;
    n_vec++;
    if (o_y !== DIG_ZERO) begin
      n_err++;
      $display("FAIL mid_async_clear: o_y=%b expected %b", o_y, DIG_ZERO);
    end
    @(negedge i_clk);
    i_Reset = 1'b1;
    run_edges(9);
    n_vec++;
    if (y_got[1] !== DIG_ZERO) begin
      n_err++;
      $display("FAIL mid_rerun_slot: o_y=%b expected %b", y_got[1], DIG_ZERO);
    end
    for (int k = 1; k <= 8; k++) begin
      n_vec++;
      if (y_got[k+1] !== exp_case1(k)) begin
        n_err++;
        $display("FAIL mid_rerun_digit y%0d: o_y=%b expected %b", k, y_got[k+1], exp_case1(k));
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    i_Reset = 1'b0;
    i_x     = DIG_ZERO;
    test_reset();
    test_case1();
    test_quarter();
    test_redundant_quarter();
    test_all_ones();
    test_zero();
    test_code11_input();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
